sram_like_arbiter: RTL and testbench

- Arbitrates NUM_CH upstream masters onto one downstream SRAM-like bus that uses a req/addr_ok/data_ok handshake. Typical masters are the IF fetch port and the EXE load/store port.
- Tracks up to MAX_OUTSTANDING in-flight transactions in order and routes each data_ok/rdata back to the channel that issued it.
- Sits between the pipeline stages and the memory/cache bridge in the CPU top.

---
 rtl/sram_like_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_sram_like_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter
//   Arbitrates NUM_CH upstream masters (e.g. IF fetch, EXE load/store) onto a
//   single SRAM-like bus with a req/addr_ok/data_ok handshake. In-flight
//   transactions are tracked in issue order so that every data_ok is steered
//   back to the channel that issued it.
//
// Handshake semantics:
//   An address phase completes ("fire") in any cycle where req & addr_ok.
//   A data phase completes in any cycle where data_ok is high. Responses
//   return strictly in address-phase order. A master must hold its request
//   fields stable until it sees its ch_addr_ok bit.
//
// Ports:
//   clk, reset          clock (rising edge), synchronous active-high reset
//   ch_req/ch_wr        per-channel request / write flag
//   ch_size             per-channel size, 2 bits each (0=byte,1=half,2=word)
//   ch_wstrb            per-channel byte strobes, DATA_W/8 bits each
//   ch_addr/ch_wdata    per-channel address / write data
//   ch_addr_ok          one-hot (or zero) accept back to the granted channel
//   ch_data_ok          one-hot (or zero) response to the oldest issuer
//   ch_rdata            read data broadcast to all channels
//   req,wr,size,wstrb,addr,wdata   downstream request, muxed from the grant
//   addr_ok,data_ok,rdata          downstream accept / response / read data
//   outstanding         number of transactions in flight
//   err_unexpected      sticky flag: data_ok arrived with nothing in flight
module sram_like_arbiter #(
    parameter int NUM_CH          = 2,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_CH-1:0]                ch_req,
    input  logic [NUM_CH-1:0]                ch_wr,
    input  logic [2*NUM_CH-1:0]              ch_size,
    input  logic [NUM_CH*DATA_W/8-1:0]       ch_wstrb,
    input  logic [NUM_CH*ADDR_W-1:0]         ch_addr,
    input  logic [NUM_CH*DATA_W-1:0]         ch_wdata,
    output logic [NUM_CH-1:0]                ch_addr_ok,
    output logic [NUM_CH-1:0]                ch_data_ok,
    output logic [DATA_W-1:0]                ch_rdata,
    output logic                             req,
    output logic                             wr,
    output logic [1:0]                       size,
    output logic [DATA_W/8-1:0]              wstrb,
    output logic [ADDR_W-1:0]                addr,
    output logic [DATA_W-1:0]                wdata,
    input  logic                             addr_ok,
    input  logic                             data_ok,
    input  logic [DATA_W-1:0]                rdata,
    output logic [$clog2(MAX_OUTSTANDING):0] outstanding,
    output logic                             err_unexpected
);

    localparam int ID_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;
    localparam int SW    = DATA_W / 8;

    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic             lock_q, lock_d;
    logic [ID_W-1:0]  lock_id_q, lock_id_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             err_q, err_d;
    logic [ID_W-1:0]  fifo_q [MAX_OUTSTANDING];

    logic             full, empty, any_req, fire, pop;
    logic             hi_found;
    logic [ID_W-1:0]  scan_hi, scan_any, scan_grant, grant, head_id;

    assign full    = (cnt_q == CNT_W'(MAX_OUTSTANDING));
    assign empty   = (cnt_q == '0);
    assign head_id = fifo_q[rd_ptr_q];

    // Round-robin scan: lowest requester at or above rr_ptr wins; if none,
    // wrap around to the lowest requester overall. Descending loop so the
    // last assignment is the lowest index.
    always_comb begin
        hi_found = 1'b0;
        scan_hi  = '0;
        scan_any = '0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (ch_req[ID_W'(c)]) begin
                scan_any = ID_W'(c);
                if (ID_W'(c) >= rr_ptr_q) begin
                    scan_hi  = ID_W'(c);
                    hi_found = 1'b1;
                end
            end
        end
        scan_grant = hi_found ? scan_hi : scan_any;
    end

    assign grant = lock_q ? lock_id_q : scan_grant;

    // While locked only the locked channel's request counts, so a master that
    // drops its request mid-stall can never be pushed on behalf of another.
    assign any_req = lock_q ? ch_req[lock_id_q] : |ch_req;
    assign req     = any_req & ~full & ~reset;
    assign fire    = req & addr_ok;
    assign pop     = data_ok & ~empty & ~reset;

    // Zero-latency field mux and one-hot handshake fan-out.
    always_comb begin
        wr         = 1'b0;
        size       = '0;
        wstrb      = '0;
        addr       = '0;
        wdata      = '0;
        ch_addr_ok = '0;
        ch_data_ok = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ID_W'(c) == grant) begin
                wr    = ch_wr[ID_W'(c)];
                size  = ch_size[2*c +: 2];
                wstrb = ch_wstrb[SW*c +: SW];
                addr  = ch_addr[ADDR_W*c +: ADDR_W];
                wdata = ch_wdata[DATA_W*c +: DATA_W];
            end
            ch_addr_ok[ID_W'(c)] = fire & (ID_W'(c) == grant);
            ch_data_ok[ID_W'(c)] = pop & (ID_W'(c) == head_id);
        end
    end

    assign ch_rdata       = rdata;
    assign outstanding    = cnt_q;
    assign err_unexpected = err_q;

    // Next-state logic.
    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        cnt_d     = cnt_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        err_d     = err_q;

        if (fire) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            rr_ptr_d = (grant == ID_W'(NUM_CH - 1)) ? '0 : grant + 1'b1;
            lock_d   = 1'b0;
        end else if (lock_q && !ch_req[lock_id_q]) begin
            lock_d = 1'b0;
        end else if (req && !addr_ok) begin
            // Freeze the grant so downstream fields stay stable during a stall.
            lock_d    = 1'b1;
            lock_id_d = grant;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        if (fire && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (pop && !fire) begin
            cnt_d = cnt_q - 1'b1;
        end

        if (data_ok && empty) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q  <= '0;
            lock_q    <= 1'b0;
            lock_id_q <= '0;
            cnt_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
            cnt_q     <= cnt_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            err_q     <= err_d;
            if (fire) begin
                fifo_q[wr_ptr_q] <= grant;
            end
        end
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
module tb_sram_like_arbiter;

    localparam int NUM_CH = 2;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int MAXO   = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [NUM_CH-1:0]          ch_req;
    logic [NUM_CH-1:0]          ch_wr;
    logic [2*NUM_CH-1:0]        ch_size;
    logic [NUM_CH*DATA_W/8-1:0] ch_wstrb;
    logic [NUM_CH*ADDR_W-1:0]   ch_addr;
    logic [NUM_CH*DATA_W-1:0]   ch_wdata;
    logic [NUM_CH-1:0]          ch_addr_ok;
    logic [NUM_CH-1:0]          ch_data_ok;
    logic [DATA_W-1:0]          ch_rdata;
    logic                       req, wr;
    logic [1:0]                 size;
    logic [DATA_W/8-1:0]        wstrb;
    logic [ADDR_W-1:0]          addr;
    logic [DATA_W-1:0]          wdata;
    logic                       addr_ok, data_ok;
    logic [DATA_W-1:0]          rdata;
    logic [$clog2(MAXO):0]      outstanding;
    logic                       err_unexpected;

    logic [ADDR_W-1:0] a0, a1;
    logic [DATA_W-1:0] w0, w1;
    assign ch_addr  = {a1, a0};
    assign ch_wdata = {w1, w0};

    sram_like_arbiter #(
        .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk), .reset(reset),
        .ch_req(ch_req), .ch_wr(ch_wr), .ch_size(ch_size), .ch_wstrb(ch_wstrb),
        .ch_addr(ch_addr), .ch_wdata(ch_wdata),
        .ch_addr_ok(ch_addr_ok), .ch_data_ok(ch_data_ok), .ch_rdata(ch_rdata),
        .req(req), .wr(wr), .size(size), .wstrb(wstrb), .addr(addr), .wdata(wdata),
        .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
        .outstanding(outstanding), .err_unexpected(err_unexpected)
    );

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;
    logic [NUM_CH-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every response the DUT presents is matched against the oldest
    // expected issuer; read data must be the downstream data of that cycle.
    always @(negedge clk) begin
        logic [NUM_CH-1:0] e;
        if (ch_data_ok != '0) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL resp_unexpected ch_data_ok=%b expected none", ch_data_ok);
            end else begin
                e = exp_q.pop_front();
                if (ch_data_ok !== e || ch_rdata !== rdata) begin
                    failures++;
                    $display("FAIL resp ch_data_ok=%b rdata=0x%0h expected ch_data_ok=%b rdata=0x%0h",
                             ch_data_ok, ch_rdata, e, rdata);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    // One cycle with addr_ok=1; exp_grant is the hand-computed one-hot grant.
    task automatic fire_cycle(input logic [1:0] reqv, input logic [1:0] exp_grant, input string name);
        ch_req  = reqv;
        addr_ok = 1'b1;
        @(negedge clk);
        check(name, ch_addr_ok, exp_grant);
        if (exp_grant != 2'b00) exp_q.push_back(exp_grant);
        next_cycle;
    endtask

    task automatic drain(input int n, input logic [31:0] base);
        ch_req  = '0;
        addr_ok = 1'b0;
        for (int i = 0; i < n; i++) begin
            data_ok = 1'b1;
            rdata   = base + 32'(i);
            @(negedge clk);
            next_cycle;
        end
        data_ok = 1'b0;
        @(negedge clk);
        check("drain_outstanding", outstanding, 0);
        next_cycle;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1; ch_req = 2'b11; ch_wr = '0; ch_size = '0; ch_wstrb = '0;
        a0 = '0; a1 = '0; w0 = '0; w1 = '0;
        addr_ok = 1'b1; data_ok = 1'b1; rdata = '0;
        @(negedge clk);
        check("rst_req", req, 0);
        check("rst_addr_ok", ch_addr_ok, 0);
        check("rst_data_ok", ch_data_ok, 0);
        next_cycle;
        reset = 1'b0; ch_req = '0; addr_ok = 1'b0; data_ok = 1'b0;
        @(negedge clk);
        check("rst_outstanding", outstanding, 0);
        check("rst_err", err_unexpected, 0);
        next_cycle;

        // Single channel read on ch1.
        a1 = 32'h1C00_0100; ch_req = 2'b10; addr_ok = 1'b1;
        @(negedge clk);
        check("t1_req", req, 1);
        check("t1_addr_ok", ch_addr_ok, 2'b10);
        check("t1_addr", addr, 32'h1C00_0100);
        exp_q.push_back(2'b10);
        next_cycle;
        ch_req = '0; addr_ok = 1'b0;
        @(negedge clk);
        check("t1_outstanding", outstanding, 1);
        next_cycle;
        data_ok = 1'b1; rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        next_cycle;
        data_ok = 1'b0;
        @(negedge clk);
        check("t1_outstanding_after", outstanding, 0);
        next_cycle;

        // Round-robin fairness, filling the order FIFO with 0,1,0,1.
        fire_cycle(2'b11, 2'b01, "rr_g0");
        fire_cycle(2'b11, 2'b10, "rr_g1");
        fire_cycle(2'b11, 2'b01, "rr_g2");
        fire_cycle(2'b11, 2'b10, "rr_g3");
        ch_req = '0; addr_ok = 1'b0;
        @(negedge clk);
        check("rr_outstanding", outstanding, 4);
        next_cycle;
        drain(4, 32'h1000_0000);

        // Stall lock: rr_ptr moved to 1 first so an unlocked arbiter would
        // switch to ch1 once it requests.
        fire_cycle(2'b01, 2'b01, "lk_pre");
        a0 = 32'hA000_0000; w0 = 32'h0A0A_0A0A; a1 = 32'hB000_0000; w1 = 32'h0B0B_0B0B;
        ch_wr = 2'b01; ch_size = 4'b00_10; ch_wstrb = 8'h1F;
        ch_req = 2'b01; addr_ok = 1'b0;
        @(negedge clk);
        check("lk_c0_addr", addr, 32'hA000_0000);
        check("lk_c0_wr_size", {wr, size, wstrb}, {1'b1, 2'd2, 4'hF});
        next_cycle;
        ch_req = 2'b11;
        @(negedge clk);
        check("lk_c1_addr", addr, 32'hA000_0000);
        check("lk_c1_wdata", wdata, 32'h0A0A_0A0A);
        check("lk_c1_addr_ok", ch_addr_ok, 0);
        next_cycle;
        @(negedge clk);
        check("lk_c2_addr", addr, 32'hA000_0000);
        next_cycle;
        fire_cycle(2'b11, 2'b01, "lk_fire0");
        fire_cycle(2'b11, 2'b10, "lk_fire1");
        ch_req = '0; addr_ok = 1'b0; ch_wr = '0; ch_size = '0; ch_wstrb = '0;
        @(negedge clk);
        check("lk_outstanding", outstanding, 3);
        next_cycle;
        drain(3, 32'h2000_0000);

        // Full backpressure.
        fire_cycle(2'b01, 2'b01, "fu_0");
        fire_cycle(2'b01, 2'b01, "fu_1");
        fire_cycle(2'b01, 2'b01, "fu_2");
        fire_cycle(2'b01, 2'b01, "fu_3");
        ch_req = 2'b01; addr_ok = 1'b1;
        @(negedge clk);
        check("fu_outstanding", outstanding, 4);
        check("fu_req_blocked", req, 0);
        check("fu_addr_ok_blocked", ch_addr_ok, 0);
        next_cycle;
        data_ok = 1'b1; rdata = 32'h3000_0000;
        @(negedge clk);
        check("fu_req_same_cycle", req, 0);
        next_cycle;
        data_ok = 1'b0;
        @(negedge clk);
        check("fu_outstanding_n1", outstanding, 3);
        check("fu_req_n1", req, 1);
        check("fu_addr_ok_n1", ch_addr_ok, 2'b01);
        exp_q.push_back(2'b01);
        next_cycle;
        ch_req = '0; addr_ok = 1'b0;
        @(negedge clk);
        check("fu_refilled", outstanding, 4);
        next_cycle;
        drain(4, 32'h3100_0000);

        // Simultaneous fire and pop at outstanding=2.
        fire_cycle(2'b11, 2'b10, "sp_0");
        fire_cycle(2'b11, 2'b01, "sp_1");
        ch_req = 2'b01; addr_ok = 1'b1; data_ok = 1'b1; rdata = 32'h4000_0000;
        @(negedge clk);
        check("sp_fire", ch_addr_ok, 2'b01);
        exp_q.push_back(2'b01);
        next_cycle;
        ch_req = '0; addr_ok = 1'b0; data_ok = 1'b0;
        @(negedge clk);
        check("sp_outstanding", outstanding, 2);
        next_cycle;
        drain(2, 32'h4100_0000);

        // Unexpected data_ok, then reset with one transaction in flight.
        data_ok = 1'b1; rdata = 32'h5000_0000;
        @(negedge clk);
        check("ue_no_data_ok", ch_data_ok, 0);
        next_cycle;
        data_ok = 1'b0;
        @(negedge clk);
        check("ue_err_set", err_unexpected, 1);
        next_cycle;
        @(negedge clk);
        check("ue_err_sticky", err_unexpected, 1);
        next_cycle;
        fire_cycle(2'b01, 2'b01, "ue_inflight");
        reset = 1'b1; ch_req = '0; addr_ok = 1'b0;
        exp_q.delete();
        @(negedge clk);
        next_cycle;
        reset = 1'b0;
        @(negedge clk);
        check("ue_err_cleared", err_unexpected, 0);
        check("ue_outstanding_cleared", outstanding, 0);
        next_cycle;
        fire_cycle(2'b11, 2'b01, "ue_rr_reset");
        drain(1, 32'h6000_0000);

        @(negedge clk);
        check("sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
